// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 constants, the xtime helper and the key
//               schedule state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // AES-128 geometry: four 32-bit key words, ten rounds.
    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    // Round constant applied when deriving round key 1.
    localparam logic [7:0] RCON_INIT = 8'h01;

    // Index of the final round key, sized to the round counter.
    localparam logic [3:0] C_LAST_ROUND = 4'(AES_NR);

    // Key schedule controller states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ke_state_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/sbox.sv
`default_nettype none
// ============================================================================
// Module      : sbox
// Description : AES forward S-box, purely combinational byte lookup.
// Ports       : in_byte_i  [7:0] - byte to substitute
//               out_byte_o [7:0] - substituted byte
// Revision    : 1.0 - initial release
// ============================================================================
module sbox (
    input  logic [7:0] in_byte_i,
    output logic [7:0] out_byte_o
);

    // Entry 0 occupies the most significant byte of the table.
    localparam logic [2047:0] C_SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Top bit of entry n sits at 2047 - 8*n, which is {~n, 3'b111}.
    logic [10:0] w_msb_idx;

    assign w_msb_idx  = {~in_byte_i, 3'b111};
    assign out_byte_o = C_SBOX_TABLE[w_msb_idx -: 8];

endmodule : sbox
`default_nettype wire

// File: rtl/sub_word.sv
`default_nettype none
// ============================================================================
// Module      : sub_word
// Description : AES SubWord - applies the S-box to each byte of a 32-bit word.
//               Shared by the key schedule and the round datapath.
// Ports       : word_i [31:0] - input word
//               word_o [31:0] - byte-wise substituted word
// Revision    : 1.0 - initial release
// ============================================================================
module sub_word (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            sbox u_sbox (
                .in_byte_i  (word_i[8*gi +: 8]),
                .out_byte_o (word_o[8*gi +: 8])
            );
        end
    endgenerate

endmodule : sub_word
`default_nettype wire

// File: rtl/key_expand_128.sv
`default_nettype none
// ============================================================================
// Module      : key_expand_128
// Description : AES-128 key schedule. Emits round keys 0..10 one per
//               valid/ready handshake, starting from a loaded cipher key.
// Ports       : clk        - clock
//               rst_n      - asynchronous active-low reset
//               start      - load key_in and begin a schedule (IDLE only)
//               key_in     - cipher key, w0 in [127:96]
//               key_ready  - consumer accepts the current round key
//               key_valid  - round_key / round_num are valid
//               round_key  - current round key, same word order as key_in
//               round_num  - index of current round key, 0..10
//               busy       - schedule in progress
//               done       - one-cycle pulse after round key 10 is accepted
// Revision    : 1.0 - initial release
// ============================================================================
module key_expand_128
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic         key_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         busy,
    output logic         done
);

    ke_state_e    state_q,     state_d;
    logic [127:0] round_key_q, round_key_d;
    logic [3:0]   round_num_q, round_num_d;
    logic [7:0]   rcon_q,      rcon_d;
    logic         done_q,      done_d;

    // ------------------------------------------------------------------
    // Next round key: SubWord(RotWord(w3)) ^ rcon, then the XOR chain.
    // ------------------------------------------------------------------
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot, w_sub, w_temp;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_next_key;

    assign w_w0 = round_key_q[127:96];
    assign w_w1 = round_key_q[95:64];
    assign w_w2 = round_key_q[63:32];
    assign w_w3 = round_key_q[31:0];

    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    sub_word u_sub_word (
        .word_i (w_rot),
        .word_o (w_sub)
    );

    assign w_temp     = w_sub ^ {rcon_q, 24'h000000};
    assign w_n0       = w_w0 ^ w_temp;
    assign w_n1       = w_w1 ^ w_n0;
    assign w_n2       = w_w2 ^ w_n1;
    assign w_n3       = w_w3 ^ w_n2;
    assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

    // ------------------------------------------------------------------
    // Controller: next state and datapath updates.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        round_num_d = round_num_q;
        rcon_d      = rcon_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // done_q marks the first IDLE cycle after completion; a start
                // there is dropped so a new schedule begins one cycle later.
                if (start && !done_q) begin
                    state_d     = ST_RUN;
                    round_key_d = key_in;
                    round_num_d = 4'd0;
                    rcon_d      = RCON_INIT;
                end
            end
            ST_RUN: begin
                if (key_ready) begin
                    if (round_num_q == C_LAST_ROUND) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        round_key_d = w_next_key;
                        round_num_d = round_num_q + 4'd1;
                        rcon_d      = xtime(rcon_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            round_key_q <= '0;
            round_num_q <= 4'd0;
            rcon_q      <= RCON_INIT;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            round_num_q <= round_num_d;
            rcon_q      <= rcon_d;
            done_q      <= done_d;
        end
    end

    // Outputs are direct register values or decodes of the state register.
    assign key_valid = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign round_key = round_key_q;
    assign round_num = round_num_q;
    assign done      = done_q;

endmodule : key_expand_128
`default_nettype wire

// File: doc/key_expand_128.md
# key_expand_128

AES-128 key schedule engine that produces the eleven 128-bit round keys (round 0 to round 10) from a cipher key, one key per accepted handshake. It sits beside the round-function datapath and consumes the byte-substitution stage. It instantiates four copies of the existing `sbox` to perform SubWord on the rotated last word. The round-function controller pulls keys through a valid/ready interface.

## Interface
- No parameters. The block is AES-128 only. Nk=4 and Nr=10 are package constants.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous reset, active-low.
- `start` in 1: load `key_in` and begin a schedule. Honoured only in IDLE.
- `key_in` in 128: cipher key. Bits [127:96] are w0 and bits [7:0] are the last key byte.
- `key_ready` in 1: the consumer accepts the current round key.
- `key_valid` out 1: `round_key` and `round_num` are valid.
- `round_key` out 128: current round key, in the same word order as `key_in`.
- `round_num` out 4: index of the current round key, 0..10.
- `busy` out 1: high in state RUN.
- `done` out 1: one-cycle pulse after round key 10 has been accepted.

## Operation
States:
- IDLE: `key_valid`=0, `busy`=0.
  - `start`=1 → RUN.
  - On this transition the block loads `round_key`=`key_in`, `round_num`=0 and `rcon`=8'h01.
- RUN: `key_valid`=1, `busy`=1.
  - On `key_valid` & `key_ready` with `round_num`<10:
    - temp = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
    - w0'=w0^temp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
    - `round_num`+=1.
    - `rcon`=xtime(`rcon`), where xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - On `key_valid` & `key_ready` with `round_num`==10: → IDLE, `done`=1 for exactly one cycle.

Behaviour rules:
- RotWord({a,b,c,d}) = {b,c,d,a}. SubWord applies `sbox` to each byte.
- The `rcon` sequence over rounds 1..10 is 01,02,04,08,10,20,40,80,1b,36.
- `key_ready` low in RUN stalls the block: every output holds indefinitely.
- `start` in RUN is ignored. A schedule cannot be restarted except by reset or completion.
- `start` in the same cycle the block returns to IDLE is ignored. It is honoured from the following cycle.
- In IDLE, `round_key` and `round_num` hold their last values: key 10 and 10 after a completed schedule.
- `key_in` is sampled only on the accepted `start` cycle. Later changes have no effect.

Reset (`rst_n`=0, asynchronous, takes effect mid-schedule too):
- State goes to IDLE.
- `round_key`=0, `round_num`=0, `rcon`=8'h01.
- `key_valid`=0, `busy`=0, `done`=0.

## Timing
- Cycle T: `start`=1 in IDLE. At T+1: `key_valid`=1, `round_num`=0, `round_key`=`key_in`.
- Handshake at cycle N: the next key is present at N+1. The schedule is 1 key/cycle with `key_ready` held high.
- The whole schedule takes 11 cycles of `key_valid` with continuous ready.
- `done` is asserted in the cycle after the round-10 handshake. `key_valid` is 0 in that same cycle.
- Every output is registered. There is no combinational path from `key_ready` or `start` to any output.
- The SubWord path is combinational inside one cycle: a 4×`sbox` and XOR chain between registers.

## Structure
- Package `aes_pkg`:
  - `AES_NR`=10, `AES_NK`=4.
  - `RCON_INIT`=8'h01.
  - `xtime` function.
  - State encoding IDLE/RUN.
- Sub-module `sub_word`: 32-bit in, 32-bit out, four `sbox` instances on bytes [31:24]..[7:0]. It is reused later by the round datapath.
- Top level:
  - FSM.
  - `round_key`, `round_num` and `rcon` registers.
  - Next-key XOR chain.

## Test plan
- FIPS-197 A.1: `key_in`=2b7e151628aed2a6abf7158809cf4f3c, `key_ready`=1 throughout.
  - Round 0 = `key_in`.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` pulses at cycle T+12.
- Back-pressure: the same key with `key_ready` toggling pseudo-randomly.
  - Identical key sequence.
  - Outputs are stable whenever valid & !ready.
  - Exactly 11 handshakes, then `done`.
- Start while busy: pulse `start` with a different `key_in` at round 4. The sequence continues unchanged from the original key.
- Reset mid-operation: drop `rst_n` asynchronously at round 6, away from any clock edge.
  - Outputs go to 0 immediately.
  - After release, `start` with an all-zero key gives round 1 = 62636363626363636263636362636363.
- Back-to-back: assert `start` in the `done` cycle, then again one cycle later.
  - The first start is ignored.
  - The second is accepted, with round 0 at the next cycle.
- Rcon wrap: check the `rcon` values 80→1b→36 at rounds 8..10 against the expected round keys 8..10 of the A.1 vector.
